prv664_flush_arbiter: RTL and testbench

PRV664_FLUSH_ARBITER -- requirements
Module: prv664_flush_arbiter

---
 rtl/prv664_pkg.sv | 20 ++
 rtl/pip_flush_interface.sv | 12 +
 rtl/prv664_define.svh | 5 +
 rtl/prv664_prio_pick.sv | 23 ++
 rtl/prv664_flush_arbiter.sv | 131 +++++++++++++
 tb/tb_prv664_flush_arbiter.sv | 258 +++++++++++++++++++++++++
 6 files changed

// File: rtl/prv664_pkg.sv
// rtl/prv664_pkg.sv - shared prv664 types and parameter limits
`include "prv664_define.svh"

package prv664_pkg;

  localparam int unsigned XLEN = `XLEN;

  localparam int unsigned NSRC_MIN         = 2;
  localparam int unsigned NSRC_MAX         = 8;
  localparam int unsigned FLUSH_CYCLES_MIN = 1;
  localparam int unsigned FLUSH_CYCLES_MAX = 4;
  localparam int unsigned PULSE_W          = $clog2(FLUSH_CYCLES_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/pip_flush_interface.sv
// rtl/pip_flush_interface.sv - pipeline flush/redirect bundle
interface pip_flush_interface;
  import prv664_pkg::*;

  logic [XLEN-1:0] newpc;
  logic            flush;
  logic            hold;
  logic            flushbpu;

  modport master (output newpc, flush, hold, flushbpu);
  modport slave  (input  newpc, flush, hold, flushbpu);
endinterface

// File: rtl/prv664_define.svh
// rtl/prv664_define.svh - global core-width defines
`ifndef PRV664_DEFINE_SVH
`define PRV664_DEFINE_SVH
`define XLEN 64
`endif

// File: rtl/prv664_prio_pick.sv
// rtl/prv664_prio_pick.sv - fixed-priority picker, lowest index wins
module prv664_prio_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int unsigned IW = $clog2(N);

  // Scanning downward lets the lowest asserted index overwrite the rest.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
  end
endmodule

// File: rtl/prv664_flush_arbiter.sv
// rtl/prv664_flush_arbiter.sv - arbitrates flush sources into one registered
// redirect/flush/hold stream for the pipeline
module prv664_flush_arbiter
  import prv664_pkg::*;
#(
  parameter int unsigned NSRC         = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  pip_flush_interface.master         flush_master,
  input  logic [NSRC-1:0]            src_req_i,
  input  logic [NSRC-1:0][XLEN-1:0]  src_pc_i,
  input  logic [NSRC-1:0]            src_bpu_i,
  input  logic                       hold_req_i,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           flush_cnt_o,
  output logic [$clog2(NSRC)-1:0]    flush_src_o
);
  localparam int unsigned IDX_W  = $clog2(NSRC);
  localparam int unsigned FC_EFF =
    (FLUSH_CYCLES < FLUSH_CYCLES_MIN) ? FLUSH_CYCLES_MIN :
    (FLUSH_CYCLES > FLUSH_CYCLES_MAX) ? FLUSH_CYCLES_MAX : FLUSH_CYCLES;
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(FC_EFF - 1);

  flush_state_e       state_q, state_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               bpu_q, bpu_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic               hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NSRC-1:0]    gnt;
  logic [IDX_W-1:0]   win_idx;
  logic [XLEN-1:0]    win_pc;
  logic               win_bpu;
  logic               any_req;
  logic               accept;

  prv664_prio_pick #(.N(NSRC)) u_pick (
    .req_i (src_req_i),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

  assign any_req = |src_req_i;

  always_comb begin
    win_pc  = '0;
    win_bpu = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (gnt[i]) begin
        win_pc  = win_pc | src_pc_i[i];
        win_bpu = win_bpu | src_bpu_i[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    pc_d    = pc_q;
    bpu_d   = bpu_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, HOLD: begin
        if (any_req) begin
          accept  = 1'b1;
          state_d = FLUSH;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else if (hold_req_i) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        // Only an older source may preempt; it restarts the pulse without a gap.
        if (any_req && (win_idx < src_q)) begin
          accept = 1'b1;
        end else if (pulse_q != '0) begin
          pulse_d = pulse_q - 1'b1;
        end else if (hold_req_i) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      pc_d    = win_pc;
      bpu_d   = win_bpu;
      src_d   = win_idx;
      pulse_d = PULSE_LOAD;
    end
    hold_d = (state_d == HOLD) || ((state_d == FLUSH) && hold_req_i);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      pulse_q <= '0;
      pc_q    <= '0;
      bpu_q   <= 1'b0;
      src_q   <= '0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      pc_q    <= pc_d;
      bpu_q   <= bpu_d;
      src_q   <= src_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flush_master.flush    = (state_q == FLUSH);
  assign flush_master.flushbpu = (state_q == FLUSH) && bpu_q;
  assign flush_master.hold     = hold_q;
  assign flush_master.newpc    = pc_q;
  assign busy_o                = (state_q != IDLE);
  assign flush_cnt_o           = cnt_q;
  assign flush_src_o           = src_q;
endmodule

// File: tb/tb_prv664_flush_arbiter.sv
// tb/tb_prv664_flush_arbiter.sv - three arbiter configurations against a
// behavioural model, plus directed scenarios with literal expectations
module tb_prv664_flush_arbiter;
  localparam int XL = prv664_pkg::XLEN;

  logic clk = 1'b0;
  logic arstn;
  logic [3:0]         req;
  logic [3:0]         bpu;
  logic [3:0][XL-1:0] pcs;
  logic               hreq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pip_flush_interface if_a ();
  pip_flush_interface if_b ();
  pip_flush_interface if_c ();
  logic        busy_a, busy_b, busy_c;
  logic [31:0] cnt_a, cnt_c;
  logic [3:0]  cnt_b;
  logic [1:0]  src_a, src_b, src_c;

  prv664_flush_arbiter #(.NSRC(4), .FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .clk_i(clk), .arstn_i(arstn), .flush_master(if_a), .src_req_i(req), .src_pc_i(pcs),
    .src_bpu_i(bpu), .hold_req_i(hreq), .busy_o(busy_a), .flush_cnt_o(cnt_a), .flush_src_o(src_a));
  prv664_flush_arbiter #(.NSRC(4), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk_i(clk), .arstn_i(arstn), .flush_master(if_b), .src_req_i(req), .src_pc_i(pcs),
    .src_bpu_i(bpu), .hold_req_i(hreq), .busy_o(busy_b), .flush_cnt_o(cnt_b), .flush_src_o(src_b));
  prv664_flush_arbiter #(.NSRC(4), .FLUSH_CYCLES(4), .CNT_W(32)) dut_c (
    .clk_i(clk), .arstn_i(arstn), .flush_master(if_c), .src_req_i(req), .src_pc_i(pcs),
    .src_bpu_i(bpu), .hold_req_i(hreq), .busy_o(busy_c), .flush_cnt_o(cnt_c), .flush_src_o(src_c));

  logic          o_flush[3], o_hold[3], o_fbpu[3], o_busy[3];
  logic [XL-1:0] o_pc[3];
  logic [31:0]   o_cnt[3];
  logic [1:0]    o_src[3];
  assign o_flush[0] = if_a.flush;  assign o_flush[1] = if_b.flush;  assign o_flush[2] = if_c.flush;
  assign o_hold[0]  = if_a.hold;   assign o_hold[1]  = if_b.hold;   assign o_hold[2]  = if_c.hold;
  assign o_fbpu[0]  = if_a.flushbpu; assign o_fbpu[1] = if_b.flushbpu; assign o_fbpu[2] = if_c.flushbpu;
  assign o_pc[0]    = if_a.newpc;  assign o_pc[1]    = if_b.newpc;  assign o_pc[2]    = if_c.newpc;
  assign o_busy[0]  = busy_a;      assign o_busy[1]  = busy_b;      assign o_busy[2]  = busy_c;
  assign o_cnt[0]   = cnt_a;       assign o_cnt[1]   = {28'd0, cnt_b}; assign o_cnt[2] = cnt_c;
  assign o_src[0]   = src_a;       assign o_src[1]   = src_b;       assign o_src[2]   = src_c;

  // Model: "left" = flush cycles still to show, hq = hold request seen at the last edge.
  typedef struct {
    bit            in_flush;
    bit            in_hold;
    int            left;
    logic [XL-1:0] pc;
    bit            bpu;
    int            src;
    bit            hq;
    longint        count;
  } mdl_t;

  mdl_t   m[3];
  int     fc_of[3]   = '{1, 3, 4};
  longint cmax_of[3] = '{64'hFFFF_FFFF, 15, 64'hFFFF_FFFF};

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.in_flush = 0; r.in_hold = 0; r.left = 0; r.pc = '0;
    r.bpu = 0; r.src = 0; r.hq = 0; r.count = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t cur, int fc, longint cmax);
    mdl_t n = cur;
    int win = -1;
    for (int i = 3; i >= 0; i--) if (req[i]) win = i;
    if (!cur.in_flush) begin
      if (win >= 0) begin
        n.in_flush = 1; n.in_hold = 0; n.left = fc;
        n.pc = pcs[win]; n.bpu = bpu[win]; n.src = win;
        if (n.count < cmax) n.count = n.count + 1;
      end else begin
        n.in_hold = hreq;
      end
    end else if (win >= 0 && win < cur.src) begin
      n.left = fc; n.pc = pcs[win]; n.bpu = bpu[win]; n.src = win;
    end else if (cur.left > 1) begin
      n.left = cur.left - 1;
    end else begin
      n.in_flush = 0; n.in_hold = hreq;
    end
    n.hq = hreq;
    return n;
  endfunction

  always @(posedge clk or negedge arstn) begin
    for (int d = 0; d < 3; d++)
      m[d] = !arstn ? mdl_reset() : mdl_step(m[d], fc_of[d], cmax_of[d]);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d.flush", d), 64'(o_flush[d]), 64'(m[d].in_flush));
      chk($sformatf("d%0d.hold", d),  64'(o_hold[d]),  64'(m[d].in_hold || (m[d].in_flush && m[d].hq)));
      chk($sformatf("d%0d.fbpu", d),  64'(o_fbpu[d]),  64'(m[d].in_flush && m[d].bpu));
      chk($sformatf("d%0d.newpc", d), 64'(o_pc[d]),    64'(m[d].pc));
      chk($sformatf("d%0d.busy", d),  64'(o_busy[d]),  64'(m[d].in_flush || m[d].in_hold));
      chk($sformatf("d%0d.cnt", d),   64'(o_cnt[d]),   64'(m[d].count));
      chk($sformatf("d%0d.src", d),   64'(o_src[d]),   64'(m[d].src));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    req = '0; hreq = 1'b0; bpu = '0;
    step();
    arstn = 1'b1;
  endtask

  int total;

  initial begin
    arstn = 1'b0; req = '0; bpu = '0; pcs = '0; hreq = 1'b0;
    repeat (2) step();
    chk("rst.flush", 64'(if_a.flush), 64'd0);
    chk("rst.hold",  64'(if_a.hold),  64'd0);
    chk("rst.newpc", 64'(if_a.newpc), 64'd0);
    chk("rst.busy",  64'(busy_c),     64'd0);
    chk("rst.cnt",   64'(cnt_b),      64'd0);
    chk("rst.src",   64'(src_a),      64'd0);

    // Two sources, lower index wins; accepted on the first edge after release.
    arstn = 1'b1;
    req = 4'b0110; pcs[1] = 64'h1000; pcs[2] = 64'h2000; bpu = 4'b0010;
    step();
    chk("s031.flush", 64'(if_a.flush),    64'd1);
    chk("s031.newpc", 64'(if_a.newpc),    64'h1000);
    chk("s031.src",   64'(src_a),         64'd1);
    chk("s031.cnt",   64'(cnt_a),         64'd1);
    chk("s031.fbpu",  64'(if_a.flushbpu), 64'd1);
    req = '0;
    step();
    chk("s031.end",   64'(if_a.flush),    64'd0);
    chk("s031.keep",  64'(if_a.newpc),    64'h1000);

    // Preemption by an older source restarts the pulse (FLUSH_CYCLES=3).
    do_reset();
    req = 4'b0100; pcs[2] = 64'h2000;
    step();
    total = int'(if_b.flush);
    chk("s032.pc0", 64'(if_b.newpc), 64'h2000);
    req = 4'b0001; pcs[0] = 64'h80;
    step();
    total += int'(if_b.flush);
    chk("s032.pc1", 64'(if_b.newpc), 64'h80);
    chk("s032.src", 64'(src_b), 64'd0);
    req = '0;
    repeat (8) begin step(); total += int'(if_b.flush); end
    chk("s032.len", 64'(total), 64'd4);
    chk("s032.cnt", 64'(cnt_b), 64'd1);

    // A younger source during FLUSH is ignored (FLUSH_CYCLES=4).
    do_reset();
    req = 4'b0010; pcs[1] = 64'h1100; pcs[3] = 64'h3300;
    step();
    total = int'(if_c.flush);
    req = 4'b1000;
    repeat (2) begin step(); total += int'(if_c.flush); end
    chk("s033.pc",  64'(if_c.newpc), 64'h1100);
    req = '0;
    repeat (8) begin step(); total += int'(if_c.flush); end
    chk("s033.len", 64'(total), 64'd4);
    chk("s033.cnt", 64'(cnt_c), 64'd1);

    // Hold from IDLE, then a flush accepted from HOLD keeps hold asserted.
    do_reset();
    hreq = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); chk($sformatf("s034.hold%0d", i), 64'(if_a.hold), 64'd1); end
    hreq = 1'b0;
    step();
    chk("s034.free", 64'(busy_a), 64'd0);
    hreq = 1'b1;
    repeat (3) step();
    req = 4'b0001; pcs[0] = 64'h4000;
    step();
    chk("s034.flush", 64'(if_a.flush), 64'd1);
    chk("s034.hflsh", 64'(if_a.hold),  64'd1);
    req = '0;
    step();
    chk("s034.back", 64'(if_a.hold), 64'd1);
    hreq = 1'b0;
    step();
    chk("s034.idle", 64'(busy_a), 64'd0);

    // Reset in the 2nd FLUSH cycle aborts with no residual pulse.
    do_reset();
    req = 4'b0100; pcs[2] = 64'h3000;
    step();
    req = '0;
    step();
    chk("s035.pre", 64'(if_c.flush), 64'd1);
    arstn = 1'b0;
    #1;
    chk("s035.flush", 64'(if_c.flush), 64'd0);
    chk("s035.newpc", 64'(if_c.newpc), 64'd0);
    chk("s035.busy",  64'(busy_c),     64'd0);
    chk("s035.cnt",   64'(cnt_c),      64'd0);
    step();
    arstn = 1'b1;
    total = 0;
    repeat (6) begin step(); total += int'(if_c.flush); end
    chk("s035.after", 64'(total), 64'd0);

    // 20 flushes into a 4-bit counter saturate at 15.
    do_reset();
    for (int f = 0; f < 20; f++) begin
      req = 4'b0010; pcs[1] = 64'(f);
      step();
      req = '0;
      for (int k = 0; k < 10 && busy_b; k++) step();
      chk("s036.drain", 64'(busy_b), 64'd0);
    end
    chk("s036.sat", 64'(cnt_b), 64'd15);

    // Randomized traffic; the per-cycle compare process does the checking.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      bpu = 4'($urandom);
      for (int i = 0; i < 4; i++) pcs[i] = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) hreq = ~hreq;
      if ($urandom_range(0, 299) == 0) begin
        arstn = 1'b0;
        step();
        arstn = 1'b1;
      end else begin
        step();
      end
    end
    req = '0; hreq = 1'b0;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
